// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin arbiter in front of one pipelined Wishbone slave.
// The grant is held for a whole bus cycle, and acks are steered back to the master that issued them.
module wb_rr_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_m0_cyc,
    input  logic              i_m0_stb,
    input  logic              i_m0_we,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_data,
    output logic              o_m0_ack,
    output logic              o_m0_stall,
    output logic [DATA_W-1:0] o_m0_data,
    input  logic              i_m1_cyc,
    input  logic              i_m1_stb,
    input  logic              i_m1_we,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_data,
    output logic              o_m1_ack,
    output logic              o_m1_stall,
    output logic [DATA_W-1:0] o_m1_data,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [ADDR_W-1:0] o_wb_addr,
    output logic [DATA_W-1:0] o_wb_data,
    input  logic              i_wb_ack,
    input  logic              i_wb_stall,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic [1:0]        o_grant,
    output logic              o_proto_err
);
    localparam int               CNT_W   = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, DRAIN} state_t;

    state_t           state_q;
    logic             last_q;
    logic [CNT_W-1:0] out_cnt_q;
    logic [CNT_W-1:0] out_cnt_d;
    logic             drain_id_q;
    logic             proto_err_q;
    logic             full;
    logic             sel1;
    logic             inc;
    logic             dec;

    assign full = (out_cnt_q == CNT_MAX);
    // While draining, the aborted master keeps steering the (unstrobed) slave lines.
    assign sel1 = (state_q == GNT1) || ((state_q == DRAIN) && drain_id_q);

    always_comb begin
        o_wb_cyc   = (state_q != IDLE);
        o_wb_stb   = 1'b0;
        o_wb_we    = sel1 ? i_m1_we   : i_m0_we;
        o_wb_addr  = sel1 ? i_m1_addr : i_m0_addr;
        o_wb_data  = sel1 ? i_m1_data : i_m0_data;
        o_m0_ack   = 1'b0;
        o_m1_ack   = 1'b0;
        o_m0_stall = 1'b1;
        o_m1_stall = 1'b1;
        o_grant    = 2'b00;
        case (state_q)
            GNT0: begin
                o_wb_stb   = i_m0_stb & ~full;
                o_m0_stall = i_wb_stall | full;
                o_m0_ack   = i_wb_ack;
                o_grant    = 2'b01;
            end
            GNT1: begin
                o_wb_stb   = i_m1_stb & ~full;
                o_m1_stall = i_wb_stall | full;
                o_m1_ack   = i_wb_ack;
                o_grant    = 2'b10;
            end
            default: ;
        endcase
    end

    assign o_m0_data   = i_wb_data;
    assign o_m1_data   = i_wb_data;
    assign o_proto_err = proto_err_q;

    // An ack with nothing outstanding never drives the count below zero.
    assign inc = o_wb_stb & ~i_wb_stall;
    assign dec = i_wb_ack & (out_cnt_q != '0);

    always_comb begin
        out_cnt_d = out_cnt_q;
        if (inc && !dec) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end else if (!inc && dec) begin
            out_cnt_d = out_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            out_cnt_q   <= '0;
            drain_id_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            out_cnt_q <= out_cnt_d;
            if (i_wb_ack && (out_cnt_q == '0)) begin
                proto_err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (i_m0_cyc && (!i_m1_cyc || last_q)) begin
                        state_q <= GNT0;
                        last_q  <= 1'b0;
                    end else if (i_m1_cyc) begin
                        state_q <= GNT1;
                        last_q  <= 1'b1;
                    end
                end
                GNT0: begin
                    if (!i_m0_cyc) begin
                        state_q    <= (out_cnt_d == '0) ? IDLE : DRAIN;
                        drain_id_q <= 1'b0;
                    end
                end
                GNT1: begin
                    if (!i_m1_cyc) begin
                        state_q    <= (out_cnt_d == '0) ? IDLE : DRAIN;
                        drain_id_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_cnt_d == '0) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: two scripted masters, a delay-line slave model and an in-order ack scoreboard.
`timescale 1ns/1ps
module tb_wb_rr_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          m0_cyc, m0_stb, m0_we, m0_ack, m0_stall;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdat, m0_rdat;
    logic          m1_cyc, m1_stb, m1_we, m1_ack, m1_stall;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdat, m1_rdat;
    logic          wb_cyc, wb_stb, wb_we, wb_ack, wb_stall;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_wdat, wb_rdat;
    logic [1:0]    grant;
    logic          perr;

    always #5 clk = ~clk;

    wb_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)) dut (
        .clk(clk), .resetn(resetn),
        .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_data(m0_wdat),
        .o_m0_ack(m0_ack), .o_m0_stall(m0_stall), .o_m0_data(m0_rdat),
        .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_data(m1_wdat),
        .o_m1_ack(m1_ack), .o_m1_stall(m1_stall), .o_m1_data(m1_rdat),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr), .o_wb_data(wb_wdat),
        .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_data(wb_rdat),
        .o_grant(grant), .o_proto_err(perr)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input int i);
        return 32'hA500_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    // Slave model: fixed ack delay, data captured at acceptance.
    logic [DW-1:0] smem [0:15];
    logic          dl_v [0:7];
    logic [DW-1:0] dl_d [0:7];
    int            cur_delay = 1;
    logic          spur = 1'b0;
    logic          sacc;
    int            cyc_n = 0;
    int            out_bus = 0;
    int            max_out = 0;
    int            acc_t[$];
    int            acc_hist[$];

    assign wb_ack  = dl_v[0] | spur;
    assign wb_rdat = dl_d[0];
    assign sacc    = wb_stb & ~wb_stall;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 8; i++) begin
                dl_v[i] <= 1'b0;
                dl_d[i] <= '0;
            end
            for (int i = 0; i < 16; i++) smem[i] <= init_val(i);
            out_bus <= 0;
        end else begin
            for (int i = 0; i < 7; i++) begin
                dl_v[i] <= dl_v[i+1];
                dl_d[i] <= dl_d[i+1];
            end
            dl_v[7] <= 1'b0;
            if (sacc) begin
                dl_v[cur_delay-1] <= 1'b1;
                dl_d[cur_delay-1] <= smem[wb_addr[3:0]];
                if (wb_we) smem[wb_addr[3:0]] <= wb_wdat;
                acc_t.push_back(cyc_n);
                acc_hist.push_back(cyc_n);
            end
            out_bus <= out_bus + (sacc ? 1 : 0) - (dl_v[0] ? 1 : 0);
        end
    end

    typedef struct {
        int            m;
        logic          rd;
        logic [DW-1:0] d;
        logic          sw;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] ref_mem [0:15];
    int            last_ack_cyc = 0;
    int            ack0_cnt = 0;
    int            ack1_hist[$];

    always @(negedge clk) begin
        if (resetn) begin
            if (out_bus > max_out) max_out = out_bus;
            if (dl_v[0]) begin
                last_ack_cyc = cyc_n;
                if (acc_t.size() > 0) chk("ack_latency", 64'(cyc_n - acc_t.pop_front()), 64'(cur_delay));
                if (exp_q.size() == 0) begin
                    chk("ack_unexpected", 64'(1), 64'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("m0_ack", 64'(m0_ack), 64'(mon_e.m == 0 && !mon_e.sw));
                    chk("m1_ack", 64'(m1_ack), 64'(mon_e.m == 1 && !mon_e.sw));
                    if (mon_e.rd && !mon_e.sw)
                        chk("rd_data", 64'((mon_e.m == 0) ? m0_rdat : m1_rdat), 64'(mon_e.d));
                end
            end else begin
                chk("m0_noack", 64'(m0_ack), 64'(0));
                chk("m1_noack", 64'(m1_ack), 64'(0));
            end
            if (grant == 2'b01) chk("m1_held_stall", 64'(m1_stall), 64'(1));
            if (grant == 2'b10) chk("m0_held_stall", 64'(m0_stall), 64'(1));
            if (m0_ack) ack0_cnt++;
            if (m1_ack) ack1_hist.push_back(cyc_n);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_xfer(input int m, input logic we, input logic [3:0] a, input logic [DW-1:0] d,
                          input logic sw);
        exp_t e;
        bit   acc;
        int   t;
        e.m  = m;
        e.rd = !we;
        e.d  = ref_mem[a];
        e.sw = sw;
        if (we) ref_mem[a] = d;
        exp_q.push_back(e);
        if (m == 0) begin
            m0_stb = 1'b1; m0_we = we; m0_addr = AW'(a); m0_wdat = d;
        end else begin
            m1_stb = 1'b1; m1_we = we; m1_addr = AW'(a); m1_wdat = d;
        end
        acc = 1'b0;
        t = 0;
        while (!acc && t < 100) begin
            @(negedge clk);
            acc = (m == 0) ? !m0_stall : !m1_stall;
            tick();
            t++;
        end
        if (!acc) chk("accept_timeout", 64'(0), 64'(1));
        if (m == 0) m0_stb = 1'b0;
        else        m1_stb = 1'b0;
    endtask

    task automatic wait_grant(input logic [1:0] g, output int at);
        int t;
        t = 0;
        while (grant !== g && t < 100) begin
            tick();
            t++;
        end
        at = cyc_n;
        if (grant !== g) chk("grant_timeout", 64'(grant), 64'(g));
    endtask

    task automatic wait_sb();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            tick();
            t++;
        end
        if (exp_q.size() != 0) chk("sb_drain_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cyc"},   64'(wb_cyc), 64'(0));
        chk({tag, "_stb"},   64'(wb_stb), 64'(0));
        chk({tag, "_acks"},  64'({m0_ack, m1_ack}), 64'(0));
        chk({tag, "_stall"}, 64'({m0_stall, m1_stall}), 64'(2'b11));
        chk({tag, "_grant"}, 64'(grant), 64'(0));
        chk({tag, "_perr"},  64'(perr), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

    initial begin
        int at;
        resetn = 1'b1;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_addr = '0; m0_wdat = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_addr = '0; m1_wdat = '0;
        wb_stall = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
        #1 resetn = 1'b0;
        #11;
        chk_reset_outputs("rst");
        @(posedge clk);
        #1 resetn = 1'b1;
        tick();

        // tie after reset: m0 first, m1 two cycles after m0 releases, then m0 again
        m0_cyc = 1; m1_cyc = 1;
        #1 chk("tie_pre", 64'(grant), 64'(0));
        tick();
        chk("tie_first_m0", 64'(grant), 64'(2'b01));
        m0_cyc = 0;
        tick();
        chk("tie_gap", 64'(grant), 64'(0));
        tick();
        chk("tie_then_m1", 64'(grant), 64'(2'b10));
        m1_cyc = 0;
        tick();
        chk("tie_idle", 64'(grant), 64'(0));
        m0_cyc = 1; m1_cyc = 1;
        tick();
        chk("tie2_m0", 64'(grant), 64'(2'b01));
        m0_cyc = 0; m1_cyc = 0;
        tick(); tick();

        // single master write then read-back
        cur_delay = 1;
        m0_cyc = 1;
        #1 chk("gnt_lat_n", 64'(grant), 64'(0));
        tick();
        chk("gnt_lat_n1", 64'(grant), 64'(2'b01));
        m_xfer(0, 1'b1, 4'd5, 32'hDEAD_BEEF, 1'b0);
        m_xfer(0, 1'b0, 4'd5, '0, 1'b0);
        wait_sb();
        chk("single_grant", 64'(grant), 64'(2'b01));
        chk("single_m1_stall", 64'(m1_stall), 64'(1));
        m0_cyc = 0;
        tick(); tick();

        // pipelined burst of 8 reads from m1
        max_out = 0; ack0_cnt = 0; ack1_hist.delete();
        m1_cyc = 1;
        wait_grant(2'b10, at);
        for (int i = 0; i < 8; i++) m_xfer(1, 1'b0, 4'(i), '0, 1'b0);
        wait_sb();
        chk("burst_acks", 64'(ack1_hist.size()), 64'(8));
        if (ack1_hist.size() == 8) chk("burst_consec", 64'(ack1_hist[7] - ack1_hist[0]), 64'(7));
        chk("burst_maxout", 64'(max_out), 64'(1));
        chk("burst_m0_ack", 64'(ack0_cnt), 64'(0));
        m1_cyc = 0;
        tick(); tick();

        // outstanding limit with slow acks
        cur_delay = 6; acc_hist.delete();
        m0_cyc = 1;
        wait_grant(2'b01, at);
        for (int i = 0; i < 5; i++) m_xfer(0, 1'b0, 4'(i + 8), '0, 1'b0);
        wait_sb();
        chk("lim_accepts", 64'(acc_hist.size()), 64'(5));
        if (acc_hist.size() == 5) begin
            chk("lim_first4", 64'(acc_hist[3] - acc_hist[0]), 64'(3));
            chk("lim_fifth", 64'(acc_hist[4] - acc_hist[0]), 64'(7));
        end
        m0_cyc = 0;
        tick(); tick();

        // abort with 3 outstanding while m1 waits
        m0_cyc = 1;
        wait_grant(2'b01, at);
        m1_cyc = 1;
        for (int i = 0; i < 3; i++) m_xfer(0, 1'b0, 4'(i), '0, 1'b1);
        m0_cyc = 0;
        tick();
        chk("drain_grant", 64'(grant), 64'(0));
        chk("drain_cyc", 64'(wb_cyc), 64'(1));
        chk("drain_stb", 64'(wb_stb), 64'(0));
        chk("drain_m1_stall", 64'(m1_stall), 64'(1));
        wait_grant(2'b10, at);
        chk("drain_to_m1", 64'(at - last_ack_cyc), 64'(2));
        m1_cyc = 0;
        tick(); tick();

        // spurious ack in IDLE, then reset pulse mid-burst
        chk("perr_before", 64'(perr), 64'(0));
        spur = 1'b1;
        tick();
        spur = 1'b0;
        chk("perr_set", 64'(perr), 64'(1));
        m0_cyc = 1;
        wait_grant(2'b01, at);
        m_xfer(0, 1'b0, 4'd1, '0, 1'b0);
        m_xfer(0, 1'b0, 4'd2, '0, 1'b0);
        m0_stb = 1'b1;
        #3 resetn = 1'b0;
        #1 chk_reset_outputs("async_rst");
        exp_q.delete(); acc_t.delete();
        m0_stb = 1'b0; m0_cyc = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        tick();
        chk("perr_after_rst", 64'(perr), 64'(0));
        chk("grant_after_rst", 64'(grant), 64'(0));
        tick(); tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
